value_stable_rx: RTL and testbench

// - Destination-side reader for a multi-bit value carried across a clock crossing
//   by a per-bit synchronizer. Bits can land on different clk_dst edges, so the
//   raw bus may briefly show mixed old/new values.
// - This block accepts a new value only after it has held steady for

---
 rtl/value_stable_rx.sv | 145 ++++++++++++++
 tb/tb_value_stable_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/value_stable_rx.sv
// ---------------------------------------------------------------------------
// value_stable_rx
//
// Destination-side reader for a multi-bit value that crossed a clock domain
// through a per-bit synchronizer. Because individual bits may settle on
// different clk_dst edges, the raw bus can briefly show a mix of old and new
// bits. This block only accepts a value after it has been sampled unchanged
// for STABLE_CYCLES consecutive edges, then offers it to the consumer with a
// valid/ready handshake.
//
// Parameters
//   BITS           width of the transported value
//   STABLE_CYCLES  consecutive equal samples required before commit (1..255)
//
// Ports
//   clk_dst     in   destination clock, the only clock in this block
//   rst_dst_n   in   asynchronous active-low reset
//   value_in    in   synchronized, possibly skewed value from the crossing
//   value_out   out  last committed coherent value
//   value_vld   out  committed value pending consumption
//   value_rdy   in   consumer accepts value_out
//   glitch_cnt  out  saturating count of abandoned candidates
//                    (only when VALUE_STABLE_GLITCH_CNT_EN is defined)
//
// Build option
//   VALUE_STABLE_GLITCH_CNT_EN  adds the glitch_cnt port and its counter.
// ---------------------------------------------------------------------------
module value_stable_rx #(
    parameter int unsigned BITS          = 32,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic            clk_dst,
    input  logic            rst_dst_n,
    input  logic [BITS-1:0] value_in,
    output logic [BITS-1:0] value_out,
    output logic            value_vld,
    input  logic            value_rdy
`ifdef VALUE_STABLE_GLITCH_CNT_EN
    ,
    output logic [7:0]      glitch_cnt
`endif
);

    localparam int unsigned CNT_W = 8;
    // Saturation point of the stability counter; reaching it means the
    // candidate has been seen STABLE_CYCLES times in a row.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {
        TRACK = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BITS-1:0]   cand;
    logic [BITS-1:0]   cand_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [BITS-1:0]   out_nxt;
    logic              vld_nxt;
    logic              same_c;
    logic              stable_c;

    // Candidate tracking runs in both states so a value that settles while
    // HOLD is pending is ready to commit as soon as we return to TRACK.
    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        same_c   = (value_in == cand);
        stable_c = same_c && (cnt == CNT_LAST);
        if (!same_c) begin
            cand_nxt = value_in;
            cnt_nxt  = '0;
        end else if (cnt < CNT_LAST) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Next-state and output logic for the commit/handshake FSM.
    always_comb begin
        state_nxt = state;
        out_nxt   = value_out;
        vld_nxt   = value_vld;
        unique case (state)
            TRACK: begin
                // A value equal to what the consumer already has is not news.
                if (stable_c && (cand != value_out)) begin
                    out_nxt   = cand;
                    vld_nxt   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Outputs frozen until consumed; at least one vld=0 cycle
                // always follows the handshake.
                if (value_vld && value_rdy) begin
                    vld_nxt   = 1'b0;
                    state_nxt = TRACK;
                end
            end
            default: begin
                state_nxt = TRACK;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_dst or negedge rst_dst_n) begin
        if (!rst_dst_n) begin
            state     <= TRACK;
            cand      <= '0;
            cnt       <= '0;
            value_out <= '0;
            value_vld <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            value_out <= out_nxt;
            value_vld <= vld_nxt;
        end
    end

`ifdef VALUE_STABLE_GLITCH_CNT_EN
    logic glitch_c;

    // A glitch is a candidate abandoned after at least one repeat sample but
    // before it became stable; single-edge skew transients are not counted.
    always_comb begin
        glitch_c = (!same_c) && (cnt != '0) && (cnt < CNT_LAST) && (glitch_cnt != 8'hFF);
    end

    // Saturating glitch counter, cleared only by reset.
    always_ff @(posedge clk_dst or negedge rst_dst_n) begin
        if (!rst_dst_n) begin
            glitch_cnt <= '0;
        end else if (glitch_c) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_value_stable_rx.sv
// ---------------------------------------------------------------------------
// tb_value_stable_rx
//
// Directed bench for value_stable_rx (BITS=32, STABLE_CYCLES=4). Stimulus
// pushes the expected committed value and the edge at which vld must rise
// into a queue; an independent monitor pops and compares on each vld rise
// and checks hold/drop behaviour around every handshake.
// ---------------------------------------------------------------------------
module tb_value_stable_rx;

    localparam int unsigned BITS = 32;
    localparam int unsigned S    = 4;

    typedef struct {
        logic [BITS-1:0] v;
        int              e;
    } exp_t;

    logic            clk_dst = 1'b0;
    logic            rst_dst_n = 1'b0;
    logic [BITS-1:0] value_in = '0;
    logic [BITS-1:0] value_out;
    logic            value_vld;
    logic            value_rdy = 1'b1;
`ifdef VALUE_STABLE_GLITCH_CNT_EN
    logic [7:0]      glitch_cnt;
`endif

    exp_t            exp_q[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              edge_n = 0;
    logic            prev_vld = 1'b0;
    logic [BITS-1:0] prev_out = '0;
    logic            prev_rst = 1'b0;
    logic            rdy_e = 1'b0;

    value_stable_rx #(
        .BITS          (BITS),
        .STABLE_CYCLES (S)
    ) dut (
        .clk_dst   (clk_dst),
        .rst_dst_n (rst_dst_n),
        .value_in  (value_in),
        .value_out (value_out),
        .value_vld (value_vld),
        .value_rdy (value_rdy)
`ifdef VALUE_STABLE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk_dst = ~clk_dst;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic drive(input logic [BITS-1:0] v);
        @(negedge clk_dst);
        value_in = v;
    endtask

    // Expect v to commit S edges after the next posedge samples it.
    task automatic expect_commit(input logic [BITS-1:0] v, input int at_edge);
        exp_t e;
        e.v = v;
        e.e = at_edge;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_dst);
    endtask

    // Monitor: rdy is captured at the edge, outputs sampled 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_dst);
            edge_n++;
            rdy_e = value_rdy;
            #1;
            if (rst_dst_n && prev_rst) begin
                if (prev_vld && rdy_e) begin
                    check("vld_drop_after_hs", 32'(value_vld), 32'(0));
                end else if (prev_vld) begin
                    check("vld_held", 32'(value_vld), 32'(1));
                    check("out_held", value_out, prev_out);
                end else if (value_vld) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_commit: got 0x%0h expected no commit (edge %0d)",
                                 value_out, edge_n);
                    end else begin
                        e = exp_q.pop_front();
                        check("commit_value", value_out, e.v);
                        check("commit_edge", 32'(edge_n), 32'(e.e));
                    end
                end
            end
            prev_vld = value_vld;
            prev_out = value_out;
            prev_rst = rst_dst_n;
        end
    end

    initial begin
        // Reset state.
        idle(3);
        check("rst_value_out", value_out, 32'h0);
        check("rst_value_vld", 32'(value_vld), 32'(0));
`ifdef VALUE_STABLE_GLITCH_CNT_EN
        check("rst_glitch_cnt", 32'(glitch_cnt), 32'(0));
`endif
        rst_dst_n = 1'b1;

        // Power-up zero held: never commits.
        idle(20);
        check("zero_value_out", value_out, 32'h0);
        check("zero_value_vld", 32'(value_vld), 32'(0));

        // Clean change commits at k+S, vld for exactly one cycle.
        drive(32'h1234_5678);
        expect_commit(32'h1234_5678, edge_n + 1 + int'(S));
        idle(10);

        // Excursion that reverts to the committed value never commits.
        drive(32'h0000_0099);
        drive(32'h0000_0099);
        drive(32'h1234_5678);
        idle(10);
`ifdef VALUE_STABLE_GLITCH_CNT_EN
        check("glitch_after_revert", 32'(glitch_cnt), 32'(1));
`endif

        // Skewed arrival: single-cycle intermediates, only the final commits.
        drive(32'h0000_00FF);
        drive(32'h0000_FFFF);
        drive(32'hFFFF_FFFF);
        expect_commit(32'hFFFF_FFFF, edge_n + 1 + int'(S));
        idle(10);
`ifdef VALUE_STABLE_GLITCH_CNT_EN
        check("glitch_after_skew", 32'(glitch_cnt), 32'(1));
`endif

        // Transient held two cycles is abandoned; 0xB commits.
        drive(32'h0000_000A);
        drive(32'h0000_000A);
        drive(32'h0000_000B);
        expect_commit(32'h0000_000B, edge_n + 1 + int'(S));
        idle(10);
`ifdef VALUE_STABLE_GLITCH_CNT_EN
        check("glitch_after_transient", 32'(glitch_cnt), 32'(2));
`endif

        // Back-pressure: 0x5 held while 0x6 settles, 0x6 follows after a gap.
        drive(32'h0000_0005);
        value_rdy = 1'b0;
        expect_commit(32'h0000_0005, edge_n + 1 + int'(S));
        idle(6);
        drive(32'h0000_0006);
        idle(8);
        check("bp_hold_value", value_out, 32'h5);
        check("bp_hold_vld", 32'(value_vld), 32'(1));
        @(negedge clk_dst);
        value_rdy = 1'b1;
        expect_commit(32'h0000_0006, edge_n + 2);
        idle(8);

        // Asynchronous reset in the middle of HOLD discards the pending value.
        drive(32'h0000_0005);
        value_rdy = 1'b0;
        expect_commit(32'h0000_0005, edge_n + 1 + int'(S));
        idle(8);
        check("pre_reset_vld", 32'(value_vld), 32'(1));
        @(posedge clk_dst);
        #2;
        rst_dst_n = 1'b0;
        #1;
        check("async_rst_value_out", value_out, 32'h0);
        check("async_rst_value_vld", 32'(value_vld), 32'(0));
`ifdef VALUE_STABLE_GLITCH_CNT_EN
        check("async_rst_glitch_cnt", 32'(glitch_cnt), 32'(0));
`endif
        idle(2);
        rst_dst_n = 1'b1;
        value_rdy = 1'b1;
        expect_commit(32'h0000_0005, edge_n + 1 + int'(S));
        idle(10);

        // Drain with a bounded wait; anything left never committed.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk_dst);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_commit: got no commit expected 0x%0h at edge %0d", e.v, e.e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
